axi_lite_slave_regs: RTL

AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

---
 rtl/axi_lite_slave_regs_if.sv | 51 +++++
 rtl/axi_lite_slave_regs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a register-block master and axi_lite_slave_regs.
// Signal names follow the AXI naming of the register block's port list.
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register block: IRQ enable/status pair driving INTR_OUT plus six
// scratch words. AW and W are captured independently and committed together.
module axi_lite_slave_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  axi_lite_slave_regs_if.slave  s_axi,
  input  logic                  EVENT_IN,
  output logic                  INTR_OUT
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 5) == {AW{1'b0}});
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [3:0]    strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic          aw_cap_r, aw_cap_s, w_cap_r, w_cap_s;
  logic [AW-1:0] aw_addr_r, aw_addr_s;
  logic [DW-1:0] w_data_r, w_data_s;
  logic [3:0]    w_strb_r, w_strb_s;
  logic          awready_r, awready_s, wready_r, wready_s;
  logic          bvalid_r, bvalid_s;
  logic [1:0]    bresp_r, bresp_s;
  logic          arready_r, arready_s, rvalid_r, rvalid_s;
  logic [DW-1:0] rdata_r, rdata_s;
  logic [1:0]    rresp_r, rresp_s;
  logic          irq_en_r, irq_en_s, irq_stat_r, irq_stat_s, intr_r, intr_s;
  logic [5:0][DW-1:0] scratch_r, scratch_s;
  logic          commit_s;
  logic [2:0]    widx_s, ridx_s;
  logic [DW-1:0] rmux_s;
  logic          unused_prot_s;

  assign unused_prot_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // Next-state for both channels; reads use the pre-edge register values.
  always_comb begin
    aw_cap_s   = aw_cap_r;
    aw_addr_s  = aw_addr_r;
    w_cap_s    = w_cap_r;
    w_data_s   = w_data_r;
    w_strb_s   = w_strb_r;
    bvalid_s   = bvalid_r;
    bresp_s    = bresp_r;
    rvalid_s   = rvalid_r;
    rdata_s    = rdata_r;
    rresp_s    = rresp_r;
    irq_en_s   = irq_en_r;
    irq_stat_s = irq_stat_r;
    scratch_s  = scratch_r;
    rmux_s     = {DW{1'b0}};

    if (s_axi.S_AXI_AWVALID && awready_r) begin
      aw_cap_s  = 1'b1;
      aw_addr_s = s_axi.S_AXI_AWADDR;
    end else begin
      aw_cap_s  = aw_cap_r;
    end
    if (s_axi.S_AXI_WVALID && wready_r) begin
      w_cap_s  = 1'b1;
      w_data_s = s_axi.S_AXI_WDATA;
      w_strb_s = s_axi.S_AXI_WSTRB;
    end else begin
      w_cap_s  = w_cap_r;
    end

    commit_s = aw_cap_s && w_cap_s;
    widx_s   = aw_addr_s[4:2];
    if (commit_s) begin
      aw_cap_s = 1'b0;
      w_cap_s  = 1'b0;
      bvalid_s = 1'b1;
      if (addr_ok(aw_addr_s)) begin
        bresp_s = RESP_OKAY;
        case (widx_s)
          3'd0:    irq_en_s = w_strb_s[0] ? w_data_s[0] : irq_en_r;
          3'd1:    irq_stat_s = (w_strb_s[0] && w_data_s[0]) ? 1'b0 : irq_stat_r;
          default: begin
            for (int i = 2; i < 8; i++) begin
              scratch_s[i-2] = (widx_s == 3'(i)) ?
                               merge(scratch_r[i-2], w_data_s, w_strb_s) : scratch_r[i-2];
            end
          end
        endcase
      end else begin
        bresp_s = RESP_SLVERR;
      end
    end else if (bvalid_r && s_axi.S_AXI_BREADY) begin
      bvalid_s = 1'b0;
    end else begin
      bvalid_s = bvalid_r;
    end

    // A same-edge event beats a W1C clear.
    irq_stat_s = EVENT_IN ? 1'b1 : irq_stat_s;

    ridx_s = s_axi.S_AXI_ARADDR[4:2];
    case (ridx_s)
      3'd0:    rmux_s = {{(DW-1){1'b0}}, irq_en_r};
      3'd1:    rmux_s = {{(DW-1){1'b0}}, irq_stat_r};
      default: begin
        for (int i = 2; i < 8; i++) begin
          rmux_s = (ridx_s == 3'(i)) ? scratch_r[i-2] : rmux_s;
        end
      end
    endcase

    if (s_axi.S_AXI_ARVALID && arready_r) begin
      rvalid_s = 1'b1;
      if (addr_ok(s_axi.S_AXI_ARADDR)) begin
        rdata_s = rmux_s;
        rresp_s = RESP_OKAY;
      end else begin
        rdata_s = {DW{1'b0}};
        rresp_s = RESP_SLVERR;
      end
    end else if (rvalid_r && s_axi.S_AXI_RREADY) begin
      rvalid_s = 1'b0;
    end else begin
      rvalid_s = rvalid_r;
    end

    awready_s = !aw_cap_s && !bvalid_s;
    wready_s  = !w_cap_s && !bvalid_s;
    arready_s = !rvalid_s;
    intr_s    = irq_en_r && irq_stat_r;
  end

  // State register with synchronous reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_cap_r   <= 1'b0;
      aw_addr_r  <= {AW{1'b0}};
      w_cap_r    <= 1'b0;
      w_data_r   <= {DW{1'b0}};
      w_strb_r   <= 4'b0000;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DW{1'b0}};
      rresp_r    <= 2'b00;
      irq_en_r   <= 1'b0;
      irq_stat_r <= 1'b0;
      intr_r     <= 1'b0;
      scratch_r  <= '0;
    end else begin
      aw_cap_r   <= aw_cap_s;
      aw_addr_r  <= aw_addr_s;
      w_cap_r    <= w_cap_s;
      w_data_r   <= w_data_s;
      w_strb_r   <= w_strb_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
      bresp_r    <= bresp_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rdata_r    <= rdata_s;
      rresp_r    <= rresp_s;
      irq_en_r   <= irq_en_s;
      irq_stat_r <= irq_stat_s;
      intr_r     <= intr_s;
      scratch_r  <= scratch_s;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_r;
  assign s_axi.S_AXI_WREADY  = wready_r;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = bresp_r;
  assign s_axi.S_AXI_ARREADY = arready_r;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;
  assign s_axi.S_AXI_RRESP   = rresp_r;
  assign INTR_OUT            = intr_r;
endmodule
